// File: rtl/sudoku_pkg.sv
// Shared types and width helpers for the sudoku checker: FSM states,
// violation encoding and the parameter-derived widths used by every file.
package sudoku_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHK_ROW = 2'd1,
    S_CHK_COL = 2'd2,
    S_CHK_BOX = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ROW  = 2'd1,
    ERR_COL  = 2'd2,
    ERR_BOX  = 2'd3
  } err_kind_e;

  function automatic int cell_w(input int box);
    return $clog2(box * box + 1);
  endfunction

  function automatic int idx_w(input int box);
    return $clog2(box * box);
  endfunction

  function automatic int addr_w(input int box);
    return $clog2(box * box * box * box);
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      S_CHK_ROW: return S_CHK_COL;
      S_CHK_COL: return S_CHK_BOX;
      default:   return S_IDLE;
    endcase
  endfunction

  function automatic err_kind_e kind_of(input state_e s);
    case (s)
      S_CHK_ROW: return ERR_ROW;
      S_CHK_COL: return ERR_COL;
      S_CHK_BOX: return ERR_BOX;
      default:   return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sudoku_checker_if.sv
// Load/check handshake and status bundle of the sudoku checker; the host
// drives it through the master modport, the checker through the slave one.
interface sudoku_checker_if
  import sudoku_pkg::*;
#(
  parameter int BOX = 3
);
  localparam int CELL_W = cell_w(BOX);
  localparam int IDX_W  = idx_w(BOX);

  logic              num_valid;
  logic [CELL_W-1:0] num;
  logic              check_start;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_kind;
  logic [IDX_W-1:0]  err_index;
  logic              full;

  modport master (
    output num_valid, num, check_start,
    input  busy, done, err, err_kind, err_index, full
  );

  modport slave (
    input  num_valid, num, check_start,
    output busy, done, err, err_kind, err_index, full
  );
endinterface

// File: rtl/sudoku_dup_tracker.sv
// Seen-mask for one row/column/box group: flags a repeated digit or an
// out-of-range value; clear marks the first cell of a new group.
module sudoku_dup_tracker #(
  parameter int SIZE = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid,
  input  logic                        clear,
  input  logic [$clog2(SIZE+1)-1:0]   value,
  output logic                        dup
);
  localparam int CELL_W = $clog2(SIZE + 1);

  logic [SIZE-1:0] seen_q, seen_d;
  logic [SIZE-1:0] base, hit;

  // NOTE: every combinational output gets a default before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    base = clear ? '0 : seen_q;
    hit  = '0;
    for (int i = 0; i < SIZE; i++) begin
      hit[i] = (value == CELL_W'(i + 1));
    end
    dup    = valid && ((|(base & hit)) || (value > CELL_W'(SIZE)));
    seen_d = valid ? (base | hit) : '0;
  end

  // NOTE: state registers use non-blocking assignments only; blocking ones
  // would make simulation order-dependent between always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_q <= '0;
    else        seen_q <= seen_d;
  end

endmodule

// File: rtl/sudoku_checker.sv
// Board store plus three-pass (row, column, box) duplicate scanner, one cell
// per cycle, aborting on the first violation.
module sudoku_checker
  import sudoku_pkg::*;
#(
  parameter int BOX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  sudoku_checker_if.slave bus
);
  localparam int SIZE   = BOX * BOX;
  localparam int NCELL  = SIZE * SIZE;
  localparam int CELL_W = cell_w(BOX);
  localparam int IDX_W  = idx_w(BOX);
  localparam int ADDR_W = addr_w(BOX);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]  grp_q, grp_d, elem_q, elem_d;
  logic [IDX_W-1:0]  err_index_q, err_index_d;
  err_kind_e         err_kind_q, err_kind_d;
  logic              full_q, full_d, done_q, done_d, err_q, err_d;
  logic [CELL_W-1:0] cells_q [NCELL];
  logic [CELL_W-1:0] cells_d [NCELL];

  logic [IDX_W-1:0]  scan_row, scan_col;
  logic [ADDR_W-1:0] scan_addr, wr_addr;
  logic [CELL_W-1:0] scan_val;
  logic              scanning, dup;

  // Group grp_q, element elem_q mapped to a board coordinate per pass.
  always_comb begin
    scan_row = grp_q;
    scan_col = elem_q;
    case (state_q)
      S_CHK_COL: begin
        scan_row = elem_q;
        scan_col = grp_q;
      end
      S_CHK_BOX: begin
        scan_row = IDX_W'((int'(grp_q) / BOX) * BOX + int'(elem_q) / BOX);
        scan_col = IDX_W'((int'(grp_q) % BOX) * BOX + int'(elem_q) % BOX);
      end
      default: ;
    endcase
  end

  assign scan_addr = ADDR_W'(int'(scan_row) * SIZE + int'(scan_col));
  assign wr_addr   = ADDR_W'(int'(row_q) * SIZE + int'(col_q));
  assign scan_val  = cells_q[scan_addr];
  assign scanning  = (state_q != S_IDLE);

  sudoku_dup_tracker #(.SIZE(SIZE)) u_dup (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (scanning),
    .clear (elem_q == '0),
    .value (scan_val),
    .dup   (dup)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    grp_d       = grp_q;
    elem_d      = elem_q;
    full_d      = full_q;
    done_d      = done_q;
    err_d       = err_q;
    err_kind_d  = err_kind_q;
    err_index_d = err_index_q;
    cells_d     = cells_q;

    if (state_q == S_IDLE) begin
      if (bus.check_start || bus.num_valid) begin
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_kind_d  = ERR_NONE;
        err_index_d = '0;
      end
      // A start request wins; a write presented in the same cycle is dropped.
      if (bus.check_start) begin
        state_d = S_CHK_ROW;
        grp_d   = '0;
        elem_d  = '0;
      end else if (bus.num_valid) begin
        cells_d[wr_addr] = bus.num;
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            row_d  = '0;
            full_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end else if (dup) begin
      state_d     = S_IDLE;
      done_d      = 1'b1;
      err_d       = 1'b1;
      err_kind_d  = kind_of(state_q);
      err_index_d = grp_q;
    end else if (elem_q != LAST) begin
      elem_d = elem_q + 1'b1;
    end else begin
      elem_d = '0;
      if (grp_q != LAST) begin
        grp_d = grp_q + 1'b1;
      end else begin
        grp_d   = '0;
        state_d = next_state(state_q);
        done_d  = (state_q == S_CHK_BOX);
      end
    end
  end

  // NOTE: the board store is cleared by reset too, because a check of a
  // partially loaded board must read unwritten cells as empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      grp_q       <= '0;
      elem_q      <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_kind_q  <= ERR_NONE;
      err_index_q <= '0;
      for (int i = 0; i < NCELL; i++) cells_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      grp_q       <= grp_d;
      elem_q      <= elem_d;
      full_q      <= full_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_kind_q  <= err_kind_d;
      err_index_q <= err_index_d;
      cells_q     <= cells_d;
    end
  end

  assign bus.busy      = scanning;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_kind  = err_kind_q;
  assign bus.err_index = err_index_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench for sudoku_checker: a 4x4 and a 9x9 instance share clock
// and reset; monitors compare each finished check against queued results.
module tb_sudoku_checker;
  import sudoku_pkg::*;

  typedef struct {
    logic       err;
    logic [1:0] kind;
    int         idx;
    int         cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t q2[$];
  exp_t q3[$];
  int   busy_cnt2 = 0, busy_cnt3 = 0;
  logic busy_prev2 = 1'b0, busy_prev3 = 1'b0;

  sudoku_checker_if #(.BOX(2)) bus2 ();
  sudoku_checker_if #(.BOX(3)) bus3 ();

  sudoku_checker #(.BOX(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  sudoku_checker #(.BOX(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_rsp(input string tag, input exp_t e, input logic done,
                             input logic err, input logic [1:0] kind,
                             input logic [31:0] idx, input int cyc);
    check({tag, "_done"},      done, 1);
    check({tag, "_err"},       err, e.err);
    check({tag, "_err_kind"},  kind, e.kind);
    check({tag, "_err_index"}, idx, e.idx);
    check({tag, "_busy_cyc"},  cyc, e.cycles);
  endtask

  task automatic sb_missing(input string tag);
    checks++;
    failures++;
    $display("FAIL %s_unexpected: check finished with no expected result queued", tag);
  endtask

  // Monitors: a falling busy edge closes a check and is scored.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt2  = 0;
      busy_prev2 = 1'b0;
    end else begin
      if (bus2.busy) busy_cnt2++;
      else if (busy_prev2) begin
        if (q2.size() == 0) sb_missing("b2");
        else compare_rsp("b2", q2.pop_front(), bus2.done, bus2.err, bus2.err_kind,
                         32'(bus2.err_index), busy_cnt2);
        busy_cnt2 = 0;
      end
      busy_prev2 = bus2.busy;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt3  = 0;
      busy_prev3 = 1'b0;
    end else begin
      if (bus3.busy) busy_cnt3++;
      else if (busy_prev3) begin
        if (q3.size() == 0) sb_missing("b3");
        else compare_rsp("b3", q3.pop_front(), bus3.done, bus3.err, bus3.err_kind,
                         32'(bus3.err_index), busy_cnt3);
        busy_cnt3 = 0;
      end
      busy_prev3 = bus3.busy;
    end
  end

  task automatic write2(input logic [2:0] v);
    bus2.num_valid = 1'b1;
    bus2.num       = v;
    @(posedge clk); #1;
    bus2.num_valid = 1'b0;
  endtask

  task automatic write3(input logic [3:0] v);
    bus3.num_valid = 1'b1;
    bus3.num       = v;
    @(posedge clk); #1;
    bus3.num_valid = 1'b0;
  endtask

  // Grid given as 16 hex nibbles, row-major, first cell in the top nibble.
  task automatic load2(input logic [63:0] grid);
    logic [3:0] nib;
    for (int i = 0; i < 16; i++) begin
      nib = grid[63-4*i -: 4];
      write2(nib[2:0]);
    end
  endtask

  task automatic start2(input exp_t e, input bit with_wr);
    q2.push_back(e);
    bus2.check_start = 1'b1;
    bus2.num_valid   = with_wr;
    bus2.num         = 3'd2;
    @(posedge clk); #1;
    bus2.check_start = 1'b0;
    bus2.num_valid   = 1'b0;
  endtask

  task automatic start3(input exp_t e);
    q3.push_back(e);
    bus3.check_start = 1'b1;
    @(posedge clk); #1;
    bus3.check_start = 1'b0;
  endtask

  task automatic wait_idle(input bit big, input string name);
    int n = 0;
    while ((big ? bus3.busy : bus2.busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_finished"}, big ? bus3.busy : bus2.busy, 0);
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus2.num_valid = 1'b0; bus2.num = '0; bus2.check_start = 1'b0;
    bus3.num_valid = 1'b0; bus3.num = '0; bus3.check_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_busy",      bus2.busy, 0);
    check("rst_done",      bus2.done, 0);
    check("rst_err",       bus2.err, 0);
    check("rst_err_kind",  bus2.err_kind, 0);
    check("rst_err_index", bus2.err_index, 0);
    check("rst_full",      bus2.full, 0);

    // 4x4 board: valid grid, then one violation of each class.
    load2(64'h1234_3412_2143_4321);
    check("full_after_16", bus2.full, 1);
    start2('{1'b0, 2'd0, 0, 48}, 1'b0);
    wait_idle(1'b0, "valid4");
    repeat (3) @(posedge clk); #1;
    check("done_held", bus2.done, 1);
    check("full_kept", bus2.full, 1);

    load2(64'h1134_3412_2143_4321);
    check("done_cleared_by_write", bus2.done, 0);
    start2('{1'b1, 2'd1, 0, 2}, 1'b0);
    wait_idle(1'b0, "row_dup");
    check("err_held", bus2.err, 1);

    load2(64'h1234_3412_2134_4321);
    check("err_cleared_by_write", bus2.err, 0);
    start2('{1'b1, 2'd2, 2, 27}, 1'b0);
    wait_idle(1'b0, "col_dup");

    load2(64'h0000_0000_0010_0001);
    start2('{1'b1, 2'd3, 3, 48}, 1'b0);
    wait_idle(1'b0, "box_dup");

    load2(64'h0000_0050_0000_0000);
    start2('{1'b1, 2'd1, 1, 7}, 1'b0);
    wait_idle(1'b0, "range4");

    // Start with a concurrent write, then writes and a start while busy.
    load2(64'h1234_3412_2143_4321);
    start2('{1'b0, 2'd0, 0, 48}, 1'b1);
    repeat (3) @(posedge clk); #1;
    bus2.num_valid   = 1'b1;
    bus2.num         = 3'd2;
    bus2.check_start = 1'b1;
    @(posedge clk); #1;
    bus2.check_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus2.num_valid = 1'b0;
    wait_idle(1'b0, "busy_ignore");
    check("ptr_row_kept", dut2.row_q, 0);
    check("ptr_col_kept", dut2.col_q, 0);
    check("full_kept_2",  bus2.full, 1);
    start2('{1'b0, 2'd0, 0, 48}, 1'b0);
    wait_idle(1'b0, "no_stray_write");

    // 9x9 board: empty board, out-of-range value.
    start3('{1'b0, 2'd0, 0, 243});
    wait_idle(1'b1, "zero9");
    write3(4'd10);
    check("done9_cleared", bus3.done, 0);
    check("ptr9_col_step", dut3.col_q, 1);
    start3('{1'b1, 2'd1, 0, 1});
    wait_idle(1'b1, "range9");

    // Refill with empties (full), then reset in the middle of the column pass.
    for (int i = 0; i < 81; i++) write3(4'd0);
    check("full9_pre_reset", bus3.full, 1);
    bus3.check_start = 1'b1;
    @(posedge clk); #1;
    bus3.check_start = 1'b0;
    repeat (91) @(posedge clk);
    #3;
    check("in_chk_col", dut3.state_q, S_CHK_COL);
    rst_n = 1'b0;
    #1;
    check("arst_busy",      bus3.busy, 0);
    check("arst_done",      bus3.done, 0);
    check("arst_err",       bus3.err, 0);
    check("arst_err_kind",  bus3.err_kind, 0);
    check("arst_err_index", bus3.err_index, 0);
    check("arst_full",      bus3.full, 0);
    check("arst_full4",     bus2.full, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 80; i++) write3(4'd0);
    check("full9_at_80", bus3.full, 0);
    write3(4'd0);
    check("full9_at_81", bus3.full, 1);
    check("ptr9_row_wrap", dut3.row_q, 0);
    check("ptr9_col_wrap", dut3.col_q, 0);

    repeat (2) @(posedge clk); #1;
    check("sb2_drained", q2.size(), 0);
    check("sb3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
